// File: rtl/median_stream_ctrl_pkg.sv
// Shared definitions for the median streaming sequencer: FSM encodings and pixel width.
package median_stream_ctrl_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/median_line_buf.sv
// One line of pixel storage. Single port: the addressed entry is read
// combinationally and, when written, updated on the clock edge, so a read and
// write to the same address in one cycle returns the previous line's pixel.
module median_line_buf
  import median_stream_ctrl_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Storage array: cleared on reset, written at the addressed entry on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/median_stream_ctrl.sv
// Streaming sequencer for an external 3x3 combinational median unit.
// Pixels arrive in raster order; two line buffers plus a 3x3 window register
// present the neighbourhood on p11..p33 (row 1 oldest line, column 3 newest),
// and the returned median is forwarded as an (IMG_W-2) x (IMG_H-2) stream of
// interior pixels.
// Optional build macro MEDIAN_OUT_REG_EN adds a registered output stage
// (latency 2, full throughput); without it med_in drives out_pixel directly.
module median_stream_ctrl
  import median_stream_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic [PIX_W-1:0] p11,
  output logic [PIX_W-1:0] p12,
  output logic [PIX_W-1:0] p13,
  output logic [PIX_W-1:0] p21,
  output logic [PIX_W-1:0] p22,
  output logic [PIX_W-1:0] p23,
  output logic [PIX_W-1:0] p31,
  output logic [PIX_W-1:0] p32,
  output logic [PIX_W-1:0] p33,
  input  logic [PIX_W-1:0] med_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e           state_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             win_valid_q, win_valid_d;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] old_rd;
  logic [PIX_W-1:0] mid_rd;
  logic             accept;
  logic             last_px;
  logic             qual;
  logic             final_hs;

  assign accept  = in_valid && in_ready;
  assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);
  // Only windows whose centre is an interior pixel produce an output; this
  // also hides the stale columns the window carries across a line wrap.
  assign qual    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

`ifdef MEDIAN_OUT_REG_EN
  logic             out_valid_q;
  logic [PIX_W-1:0] out_pixel_q;
  logic             load;

  // Output register can take the current window when empty or being drained.
  assign load      = !out_valid_q || out_ready;
  assign in_ready  = (state_q == RUN) && (!win_valid_q || load);
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  // The frame ends only when the last result has left the output register
  // and nothing is left waiting in the window stage.
  assign final_hs  = out_valid_q && out_ready && !win_valid_q;
`else
  assign in_ready  = (state_q == RUN) && (!win_valid_q || out_ready);
  assign out_valid = win_valid_q;
  assign out_pixel = med_in;
  assign final_hs  = win_valid_q && out_ready;
`endif

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  assign p11 = win_q[0][0];
  assign p12 = win_q[0][1];
  assign p13 = win_q[0][2];
  assign p21 = win_q[1][0];
  assign p22 = win_q[1][1];
  assign p23 = win_q[1][2];
  assign p31 = win_q[2][0];
  assign p32 = win_q[2][1];
  assign p33 = win_q[2][2];

  // Oldest line: takes over the middle line's pixel at this column.
  median_line_buf #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb_old (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (mid_rd),
    .rdata_o (old_rd)
  );

  // Middle line: takes the incoming pixel at this column.
  median_line_buf #(
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_lb_mid (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (in_pixel),
    .rdata_o (mid_rd)
  );

  // Frame control: IDLE -> RUN on start, RUN -> DONE on the last pixel,
  // DONE -> IDLE once the final result is taken, with a frame_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (accept && last_px) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (final_hs) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if ((state_q == IDLE) && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Window: shift left one column per accepted pixel, newest column on the right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= old_rd;
      win_q[1][2] <= mid_rd;
      win_q[2][2] <= in_pixel;
    end
  end

  // Window-stage valid: set by a qualifying accept, cleared once consumed.
  always_comb begin
    win_valid_d = win_valid_q;
    if (qual) begin
      win_valid_d = 1'b1;
`ifdef MEDIAN_OUT_REG_EN
    end else if (load) begin
      win_valid_d = 1'b0;
`else
    end else if (out_ready) begin
      win_valid_d = 1'b0;
`endif
    end
  end

  // Window-stage valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= win_valid_d;
    end
  end

`ifdef MEDIAN_OUT_REG_EN
  // Output register: captures the median whenever it is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else if (load) begin
      out_valid_q <= win_valid_q;
      out_pixel_q <= med_in;
    end
  end
`endif

endmodule

// File: tb/tb_median_stream_ctrl.sv
// Bench for median_stream_ctrl on a 5x4 frame. Drives randomized source and
// sink handshakes, emulates the external median unit, and checks every output
// against medians computed directly from the frame image.
module tb_median_stream_ctrl;

  localparam int W    = 5;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NEXP = (W - 2) * (H - 2);
`ifdef MEDIAN_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic [7:0] med_in;
  logic       in_ready, out_valid, busy, frame_done;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33, out_pixel;

  int n_vec  = 0;
  int n_fail = 0;
  int img [H][W];
  int exp_q [$];
  int pix_idx = 0;
  int out_cnt = 0;
  int fd_cnt  = 0;
  bit mon_en  = 1'b0;
  bit lat_chk = 1'b0;

  always #5 clk = ~clk;

  median_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .p11        (p11),
    .p12        (p12),
    .p13        (p13),
    .p21        (p21),
    .p22        (p22),
    .p23        (p23),
    .p31        (p31),
    .p32        (p32),
    .p33        (p33),
    .med_in     (med_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Stand-in for the external combinational median unit (sort, take middle).
  function automatic logic [7:0] sort_med(input logic [7:0] a0, a1, a2, a3, a4,
                                          a5, a6, a7, a8);
    logic [7:0] v [9];
    logic [7:0] t;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    return v[4];
  endfunction

  always_comb med_in = sort_med(p11, p12, p13, p21, p22, p23, p31, p32, p33);

  // Reference median by rank counting: the value with at most 4 smaller and
  // at least 5 smaller-or-equal entries.
  function automatic int med_count(input int v [9]);
    int lt, le;
    for (int i = 0; i < 9; i++) begin
      lt = 0; le = 0;
      for (int j = 0; j < 9; j++) begin
        if (v[j] < v[i])  lt++;
        if (v[j] <= v[i]) le++;
      end
      if (lt <= 4 && le >= 5) return v[i];
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare process, sampling on the falling edge.
  initial begin : monitor
    logic [3:0] sr;
    logic       prev_stall, prev_ov, prev_fd, q;
    logic [7:0] prev_pix;
    sr = '0; prev_stall = 0; prev_ov = 0; prev_fd = 0; prev_pix = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        sr = '0; prev_stall = 0; prev_ov = 0; prev_fd = 0;
      end else begin
        if (!busy) chk("idle_in_ready", in_ready, 0);
        if (lat_chk && sr[LAT-1]) chk("latency_valid", out_valid, 1);
        if (lat_chk && out_valid && !prev_ov) chk("valid_rise_timing", sr[LAT-1], 1);
        if (prev_stall) begin
          chk("stall_valid_hold", out_valid, 1);
          chk("stall_pixel_hold", out_pixel, prev_pix);
        end
`ifndef MEDIAN_OUT_REG_EN
        if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
`endif
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_output", exp_q.size(), 1);
          end else begin
            chk("out_pixel", out_pixel, exp_q.pop_front());
          end
          out_cnt++;
        end
        if (frame_done) begin
          fd_cnt++;
          chk("fd_after_all_outputs", out_cnt, NEXP);
          chk("fd_single_cycle", prev_fd, 0);
        end
        q = in_valid && in_ready && (pix_idx / W >= 2) && (pix_idx % W >= 2);
        sr = {sr[2:0], q};
        prev_stall = out_valid && !out_ready;
        prev_pix   = out_pixel;
        prev_ov    = out_valid;
        prev_fd    = frame_done;
      end
    end
  end

  // pat: 0 ramp, 1 impulse, 2 random. rmode: 1 always ready, 2 random, 3 one 3-cycle stall.
  task automatic run_frame(input int pat, input int vprob, input int rmode,
                           input int abort_at, input bit mid_start);
    int v [9];
    int lit [6];
    bit mid_done, stall_done, in_hs;
    int stall_left, tail;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (pat)
          0:       img[r][c] = r * W + c;
          1:       img[r][c] = (r == 2 && c == 2) ? 255 : 10;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
      end
    end
    exp_q.delete();
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        for (int k = 0; k < 9; k++) v[k] = img[r - 1 + k / 3][c - 1 + k % 3];
        exp_q.push_back(med_count(v));
      end
    end
    lit = '{6, 7, 8, 11, 12, 13};
    if (pat == 0) for (int i = 0; i < NEXP; i++) chk("model_ramp", exp_q[i], lit[i]);
    if (pat == 1) for (int i = 0; i < NEXP; i++) chk("model_impulse", exp_q[i], 10);

    pix_idx = 0; out_cnt = 0; fd_cnt = 0;
    mid_done = 0; stall_done = 0; stall_left = 0; tail = 0;
    lat_chk = (rmode == 1) && (vprob == 100);
    mon_en = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);

    for (int n = 0; n < 3000 && tail < 4; n++) begin
      in_valid = (pix_idx < NPIX) && ($urandom_range(0, 99) < vprob);
      in_pixel = in_valid ? 8'(img[pix_idx / W][pix_idx % W]) : 8'($urandom);
      start = mid_start && !mid_done && (pix_idx == 7);
      if (start) mid_done = 1;
      case (rmode)
        1: out_ready = 1'b1;
        2: out_ready = ($urandom_range(0, 99) < 65);
        default: begin
          if (stall_left > 0) begin
            out_ready = 1'b0; stall_left--;
          end else if (!stall_done && out_valid && out_cnt >= 2) begin
            out_ready = 1'b0; stall_left = 2; stall_done = 1;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      @(negedge clk);
      in_hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (in_hs) pix_idx++;
      if (abort_at > 0 && pix_idx >= abort_at) begin
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_window", p22, 0);
        chk("abort_no_frame_done", fd_cnt, 0);
        in_valid = 1'b0; start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (fd_cnt > 0) tail++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("frame_done_count", fd_cnt, 1);
    chk("output_count", out_cnt, NEXP);
    chk("busy_after_frame", busy, 0);
    chk("expected_drained", exp_q.size(), 0);
    if (rmode == 3) chk("stall_applied", stall_done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_p11", p11, 0);
    chk("reset_p22", p22, 0);
    chk("reset_p33", p33, 0);
    chk("reset_out_pixel", out_pixel, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_not_busy", busy, 0);

    run_frame(0, 100, 1, 0, 1'b0);   // ramp, full rate
    run_frame(1, 100, 1, 0, 1'b0);   // impulse rejection
    run_frame(0, 100, 3, 0, 1'b0);   // three-cycle sink stall
    run_frame(2, 100, 1, 8, 1'b0);   // reset after 8 pixels
    run_frame(0, 100, 1, 0, 1'b0);   // clean frame after the abort
    run_frame(0, 100, 1, 0, 1'b1);   // start pulsed mid-frame
    for (int i = 0; i < 4; i++) run_frame(2, 40 + 15 * i, 2, 0, 1'b0);
    for (int i = 0; i < 2; i++) run_frame(2, 100, 1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
